// File: rtl/s_axis_rq_adapt_x16_if.sv
//==============================================================================
// Module : s_axis_rq_adapt_x16_if
// Brief  : Legacy-TLP input stream plus UltraScale+ x16 RQ output stream.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface s_axis_rq_adapt_x16_if #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 32
);
    logic [DATA_WIDTH-1:0]   s_axis_rq_tdata_a;
    logic [DATA_WIDTH/8-1:0] s_axis_rq_tkeep_a;
    logic                    s_axis_rq_tlast_a;
    logic                    s_axis_rq_tuser_a;
    logic                    s_axis_rq_tvalid_a;
    logic                    s_axis_rq_tready_a;

    logic [DATA_WIDTH-1:0]   s_axis_rq_tdata;
    logic [KEEP_WIDTH-1:0]   s_axis_rq_tkeep;
    logic                    s_axis_rq_tlast;
    logic [136:0]            s_axis_rq_tuser;
    logic                    s_axis_rq_tvalid;
    logic [3:0]              s_axis_rq_tready;

    // slave: the adapter's view; master: the packetizer / core side
    modport slave (
        input  s_axis_rq_tdata_a, s_axis_rq_tkeep_a, s_axis_rq_tlast_a,
               s_axis_rq_tuser_a, s_axis_rq_tvalid_a, s_axis_rq_tready,
        output s_axis_rq_tready_a, s_axis_rq_tdata, s_axis_rq_tkeep,
               s_axis_rq_tlast, s_axis_rq_tuser, s_axis_rq_tvalid
    );

    modport master (
        output s_axis_rq_tdata_a, s_axis_rq_tkeep_a, s_axis_rq_tlast_a,
               s_axis_rq_tuser_a, s_axis_rq_tvalid_a, s_axis_rq_tready,
        input  s_axis_rq_tready_a, s_axis_rq_tdata, s_axis_rq_tkeep,
               s_axis_rq_tlast, s_axis_rq_tuser, s_axis_rq_tvalid
    );
endinterface

`default_nettype wire

// File: rtl/s_axis_rq_adapt_x16.sv
//==============================================================================
// Module : s_axis_rq_adapt_x16
// Brief  : Legacy PCIe TLP -> UltraScale+ x16 RQ descriptor adapter (512-bit).
//          Define S_AXIS_RQ_ADAPT_X16_OUTREG_EN for a registered skid output.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module s_axis_rq_adapt_x16 #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 32
) (
    input  wire logic             user_clk,
    input  wire logic             user_reset,
    s_axis_rq_adapt_x16_if.slave  bus
);

    localparam int c_TUSER_W = 137;

    typedef enum logic [2:0] {
        ST_SOP    = 3'd0,
        ST_PASS4  = 3'd1,
        ST_SHIFT3 = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DROP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [31:0]           r_carry;
    logic                  r_disc;

    logic [KEEP_WIDTH-1:0] w_in_en;
    logic [31:0]           w_dw0, w_dw1, w_dw2, w_dw3;
    logic [2:0]            w_fmt;
    logic [4:0]            w_type;
    logic                  w_hdr4;
    logic [3:0]            w_req_type;
    logic                  w_supported;
    logic [63:0]           w_addr;
    logic [127:0]          w_desc;

    logic                  w_core_ready;
    logic                  w_valid;
    logic                  w_ready_a;
    logic [DATA_WIDTH-1:0] w_data;
    logic [KEEP_WIDTH-1:0] w_keep;
    logic                  w_last;
    logic                  w_sop;
    logic                  w_disc;
    logic [3:0]            w_ptr;
    logic [c_TUSER_W-1:0]  w_user;
    state_t                w_nxt_state;
    logic                  w_in_hs;
    logic                  w_flush_hs;

    wire w_unused = &{1'b0, bus.s_axis_rq_tready[3:1]};

    always_comb begin
        w_in_en = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            w_in_en[i] = |bus.s_axis_rq_tkeep_a[4*i +: 4];
        end
    end

    assign w_dw0  = bus.s_axis_rq_tdata_a[31:0];
    assign w_dw1  = bus.s_axis_rq_tdata_a[63:32];
    assign w_dw2  = bus.s_axis_rq_tdata_a[95:64];
    assign w_dw3  = bus.s_axis_rq_tdata_a[127:96];
    assign w_fmt  = w_dw0[31:29];
    assign w_type = w_dw0[28:24];
    assign w_hdr4 = w_fmt[0];

    always_comb begin
        w_req_type  = 4'b0000;
        w_supported = 1'b1;
        case (w_type)
            5'b00000: w_req_type = w_fmt[1] ? 4'b0001 : 4'b0000;
            5'b00010: w_req_type = w_fmt[1] ? 4'b0011 : 4'b0010;
            default:  w_supported = 1'b0;
        endcase
    end

    assign w_addr = w_hdr4 ? {w_dw2, w_dw3[31:2], 2'b00} : {32'h0, w_dw2[31:2], 2'b00};

    // Length 0 means 1024 DW, hence the extra MSB of the dword count
    assign w_desc = {1'b0, 1'b0, w_dw0[13:12], w_dw0[22:20], 1'b1, 16'h0,
                     w_dw1[15:8], w_dw1[31:16], w_dw0[14], w_req_type,
                     (w_dw0[9:0] == 10'd0), w_dw0[9:0], w_addr[63:2], 2'b00};

    always_comb begin
        w_valid     = 1'b0;
        w_ready_a   = 1'b0;
        w_data      = bus.s_axis_rq_tdata_a;
        w_keep      = w_in_en;
        w_last      = bus.s_axis_rq_tlast_a;
        w_sop       = 1'b0;
        w_disc      = bus.s_axis_rq_tuser_a;
        w_nxt_state = r_state;
        case (r_state)
            ST_SOP: begin
                if (!w_supported) begin
                    w_ready_a   = 1'b1;
                    w_nxt_state = bus.s_axis_rq_tlast_a ? ST_SOP : ST_DROP;
                end else begin
                    w_sop         = 1'b1;
                    w_valid       = bus.s_axis_rq_tvalid_a;
                    w_ready_a     = w_core_ready;
                    w_data[127:0] = w_desc;
                    if (w_hdr4) begin
                        w_nxt_state = bus.s_axis_rq_tlast_a ? ST_SOP : ST_PASS4;
                    end else begin
                        // 3-DW header: payload slides up one DW behind the descriptor
                        w_data[DATA_WIDTH-1:128] = bus.s_axis_rq_tdata_a[DATA_WIDTH-33:96];
                        w_keep      = {w_in_en[KEEP_WIDTH-2:3], 4'hF};
                        w_last      = bus.s_axis_rq_tlast_a && !w_in_en[KEEP_WIDTH-1];
                        w_nxt_state = !bus.s_axis_rq_tlast_a ? ST_SHIFT3 :
                                      (w_in_en[KEEP_WIDTH-1] ? ST_FLUSH : ST_SOP);
                    end
                end
            end
            ST_PASS4: begin
                w_valid     = bus.s_axis_rq_tvalid_a;
                w_ready_a   = w_core_ready;
                w_nxt_state = bus.s_axis_rq_tlast_a ? ST_SOP : ST_PASS4;
            end
            ST_SHIFT3: begin
                w_valid     = bus.s_axis_rq_tvalid_a;
                w_ready_a   = w_core_ready;
                w_data      = {bus.s_axis_rq_tdata_a[DATA_WIDTH-33:0], r_carry};
                w_keep      = {w_in_en[KEEP_WIDTH-2:0], 1'b1};
                w_last      = bus.s_axis_rq_tlast_a && !w_in_en[KEEP_WIDTH-1];
                w_nxt_state = !bus.s_axis_rq_tlast_a ? ST_SHIFT3 :
                              (w_in_en[KEEP_WIDTH-1] ? ST_FLUSH : ST_SOP);
            end
            ST_FLUSH: begin
                w_valid     = 1'b1;
                w_data      = {{(DATA_WIDTH-32){1'b0}}, r_carry};
                w_keep      = {{(KEEP_WIDTH-1){1'b0}}, 1'b1};
                w_last      = 1'b1;
                w_disc      = r_disc;
                w_nxt_state = ST_SOP;
            end
            ST_DROP: begin
                w_ready_a   = 1'b1;
                w_nxt_state = bus.s_axis_rq_tlast_a ? ST_SOP : ST_DROP;
            end
            default: w_nxt_state = ST_SOP;
        endcase
    end

    always_comb begin
        w_ptr = 4'd0;
        if (w_last) begin
            for (int i = 0; i < KEEP_WIDTH; i++) begin
                if (w_keep[i]) w_ptr = 4'(i);
            end
        end
    end

    always_comb begin
        w_user        = '0;
        w_user[3:0]   = w_sop ? w_dw1[3:0] : 4'h0;
        w_user[11:8]  = w_sop ? w_dw1[7:4] : 4'h0;
        w_user[20]    = w_sop;
        w_user[26]    = w_last;
        w_user[31:28] = w_ptr;
        w_user[36]    = w_disc;
    end

    assign w_in_hs    = bus.s_axis_rq_tvalid_a && w_ready_a;
    assign w_flush_hs = (r_state == ST_FLUSH) && w_core_ready;

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            r_state <= ST_SOP;
            r_carry <= 32'h0;
            r_disc  <= 1'b0;
        end else begin
            if (w_in_hs || w_flush_hs) begin
                r_state <= w_nxt_state;
            end
            if (w_in_hs) begin
                r_carry <= bus.s_axis_rq_tdata_a[DATA_WIDTH-1 -: 32];
                r_disc  <= bus.s_axis_rq_tuser_a;
            end
        end
    end

    assign bus.s_axis_rq_tready_a = !user_reset && w_ready_a;

`ifdef S_AXIS_RQ_ADAPT_X16_OUTREG_EN
    localparam int c_PW = DATA_WIDTH + KEEP_WIDTH + 1 + c_TUSER_W;

    logic [c_PW-1:0] r_out_pl;
    logic [c_PW-1:0] r_skid_pl;
    logic            r_out_valid;
    logic            r_skid_valid;
    logic [c_PW-1:0] w_core_pl;
    logic            w_dn_take;

    assign w_core_pl    = {w_data, w_keep, w_last, w_user};
    assign w_core_ready = !r_skid_valid;
    assign w_dn_take    = !r_out_valid || bus.s_axis_rq_tready[0];

    // Skid entry absorbs the one beat accepted while the core side stalls
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_dn_take) begin
            if (r_skid_valid) begin
                r_out_pl     <= r_skid_pl;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_pl    <= w_core_pl;
                r_out_valid <= w_valid;
            end
        end else if (w_valid) begin
            r_skid_pl    <= w_core_pl;
            r_skid_valid <= 1'b1;
        end
    end

    assign bus.s_axis_rq_tvalid = !user_reset && r_out_valid;
    assign bus.s_axis_rq_tdata  = user_reset ? '0 : r_out_pl[c_PW-1 -: DATA_WIDTH];
    assign bus.s_axis_rq_tkeep  = user_reset ? '0 : r_out_pl[c_TUSER_W+1 +: KEEP_WIDTH];
    assign bus.s_axis_rq_tlast  = !user_reset && r_out_pl[c_TUSER_W];
    assign bus.s_axis_rq_tuser  = user_reset ? '0 : r_out_pl[c_TUSER_W-1:0];
`else
    assign w_core_ready = bus.s_axis_rq_tready[0];

    assign bus.s_axis_rq_tvalid = !user_reset && w_valid;
    assign bus.s_axis_rq_tdata  = user_reset ? '0 : w_data;
    assign bus.s_axis_rq_tkeep  = user_reset ? '0 : w_keep;
    assign bus.s_axis_rq_tlast  = !user_reset && w_last;
    assign bus.s_axis_rq_tuser  = user_reset ? '0 : w_user;
`endif

endmodule

`default_nettype wire

// File: tb/tb_s_axis_rq_adapt_x16.sv
//==============================================================================
// Module : tb_s_axis_rq_adapt_x16
// Brief  : Directed bench with a DW-stream packing model for the RQ adapter.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_s_axis_rq_adapt_x16;

    logic user_clk = 1'b0;
    logic user_reset;
    always #5 user_clk = ~user_clk;

    s_axis_rq_adapt_x16_if bus ();

    s_axis_rq_adapt_x16 dut (
        .user_clk   (user_clk),
        .user_reset (user_reset),
        .bus        (bus)
    );

    typedef struct {
        logic [511:0] data;
        logic [15:0]  keep;
        logic         last;
        logic [136:0] user;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       log_q[$];
    logic [31:0] tlp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        bp_en   = 1'b0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Model: descriptor words followed by payload DWs, packed 16 DW per beat
    task automatic model_tlp(input logic disc);
        logic [31:0] s[$];
        logic [2:0]  fmt;
        logic [4:0]  typ;
        logic [63:0] a;
        logic [31:0] rtype, cnt, d2, d3;
        int          hdr, nb, n;
        beat_t       bt;
        fmt = tlp_q[0][31:29];
        typ = tlp_q[0][28:24];
        if (typ == 5'd0)      rtype = fmt[1] ? 32'd1 : 32'd0;
        else if (typ == 5'd2) rtype = fmt[1] ? 32'd3 : 32'd2;
        else return;
        hdr = fmt[0] ? 4 : 3;
        a   = fmt[0] ? {tlp_q[2], tlp_q[3]} : {32'h0, tlp_q[2]};
        a[1:0] = 2'b00;
        cnt = (tlp_q[0][9:0] == 10'd0) ? 32'd1024 : {22'h0, tlp_q[0][9:0]};
        d2  = cnt | (rtype << 11) | ({31'h0, tlp_q[0][14]} << 15) | ({16'h0, tlp_q[1][31:16]} << 16);
        d3  = {24'h0, tlp_q[1][15:8]} | 32'h0100_0000 | ({29'h0, tlp_q[0][22:20]} << 25)
              | ({30'h0, tlp_q[0][13:12]} << 28);
        s.push_back(a[31:0]);
        s.push_back(a[63:32]);
        s.push_back(d2);
        s.push_back(d3);
        for (int i = hdr; i < tlp_q.size(); i++) s.push_back(tlp_q[i]);
        n  = s.size();
        nb = (n + 15) / 16;
        for (int b = 0; b < nb; b++) begin
            bt.data = '0;
            bt.keep = '0;
            bt.user = '0;
            for (int k = 0; k < 16; k++) begin
                if (16*b + k < n) begin
                    bt.data[32*k +: 32] = s[16*b + k];
                    bt.keep[k] = 1'b1;
                end
            end
            bt.last = (b == nb - 1);
            if (b == 0) begin
                bt.user[3:0]  = tlp_q[1][3:0];
                bt.user[11:8] = tlp_q[1][7:4];
                bt.user[20]   = 1'b1;
            end
            if (bt.last) begin
                bt.user[26]    = 1'b1;
                bt.user[31:28] = 4'(n - 1 - 16*b);
            end
            bt.user[36] = disc;
            exp_q.push_back(bt);
        end
    endtask

    task automatic mk(input logic [31:0] h0, h1, h2, h3, input int hdr, input int npay,
                      input logic [31:0] pbase);
        tlp_q.delete();
        tlp_q.push_back(h0);
        tlp_q.push_back(h1);
        tlp_q.push_back(h2);
        if (hdr == 4) tlp_q.push_back(h3);
        for (int i = 0; i < npay; i++) tlp_q.push_back(pbase + 32'(i));
    endtask

    // Called at posedge+1; returns at posedge+1 after the last driven beat is taken
    task automatic send_tlp(input logic disc, input int max_beats);
        int   nb;
        int   guard;
        logic hs;
        model_tlp(disc);
        nb = (tlp_q.size() + 15) / 16;
        for (int b = 0; b < nb && b < max_beats; b++) begin
            bus.s_axis_rq_tdata_a = '0;
            bus.s_axis_rq_tkeep_a = '0;
            for (int k = 0; k < 16; k++) begin
                if (16*b + k < tlp_q.size()) begin
                    bus.s_axis_rq_tdata_a[32*k +: 32] = tlp_q[16*b + k];
                    bus.s_axis_rq_tkeep_a[4*k +: 4]   = 4'hF;
                end
            end
            bus.s_axis_rq_tlast_a  = (b == nb - 1);
            bus.s_axis_rq_tuser_a  = disc;
            bus.s_axis_rq_tvalid_a = 1'b1;
            guard = 0;
            do begin
                @(negedge user_clk);
                hs = bus.s_axis_rq_tready_a;
                @(posedge user_clk);
                #1;
                guard++;
            end while (!hs && guard < 500);
            if (!hs) fail_now("input_handshake");
        end
        bus.s_axis_rq_tvalid_a = 1'b0;
        bus.s_axis_rq_tlast_a  = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(posedge user_clk);
            #1;
            guard++;
        end
        if (exp_q.size() != 0) fail_now("drain");
        repeat (3) @(posedge user_clk);
        #1;
    endtask

    initial begin
        bus.s_axis_rq_tready = 4'b0001;
        forever begin
            @(posedge user_clk);
            #1;
            bus.s_axis_rq_tready = bp_en ? {3'b000, 1'($urandom_range(0, 1))} : 4'b0001;
        end
    end

    // Compare process: every accepted output beat against the model, plus hold checks
    initial begin
        beat_t act, hold, e;
        logic  stalled = 1'b0;
        forever begin
            @(negedge user_clk);
            act.data = bus.s_axis_rq_tdata;
            act.keep = bus.s_axis_rq_tkeep;
            act.last = bus.s_axis_rq_tlast;
            act.user = bus.s_axis_rq_tuser;
            if (stalled && !user_reset) begin
                check("stall_hold_data", act.data, hold.data);
                check("stall_hold_ctl", {bus.s_axis_rq_tvalid, act.last, act.keep, act.user},
                      {1'b1, hold.last, hold.keep, hold.user});
            end
            stalled = 1'b0;
            if (!user_reset && bus.s_axis_rq_tvalid) begin
                if (bus.s_axis_rq_tready[0]) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_output_beat");
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", act.data, e.data);
                        check("beat_keep", act.keep, e.keep);
                        check("beat_last", act.last, e.last);
                        check("beat_user", act.user, e.user);
                    end
                    log_q.push_back(act);
                end else begin
                    hold    = act;
                    stalled = 1'b1;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.s_axis_rq_tdata_a  = '0;
        bus.s_axis_rq_tkeep_a  = '0;
        bus.s_axis_rq_tlast_a  = 1'b0;
        bus.s_axis_rq_tuser_a  = 1'b0;
        bus.s_axis_rq_tvalid_a = 1'b0;
        user_reset = 1'b1;
        repeat (3) @(posedge user_clk);
        @(negedge user_clk);
        check("reset_tvalid", bus.s_axis_rq_tvalid, 1'b0);
        check("reset_tready_a", bus.s_axis_rq_tready_a, 1'b0);
        check("reset_tdata", bus.s_axis_rq_tdata, '0);
        check("reset_tkeep", bus.s_axis_rq_tkeep, 16'h0);
        @(posedge user_clk);
        #1;
        user_reset = 1'b0;
        @(posedge user_clk);
        #1;

        // 4-DW MWr, len 2, 64-bit address
        base = log_q.size();
        mk(32'h6000_0002, 32'h0100_15FF, 32'h0000_0001, 32'h2345_6780, 4, 2, 32'hA000_0000);
        send_tlp(1'b0, 99);
        drain();
        check("t1_beats", 32'(log_q.size() - base), 32'd1);
        if (log_q.size() > base) begin
            check("t1_desc", log_q[base].data[127:0], 128'h0100_0015_0100_0802_0000_0001_2345_6780);
            check("t1_payload", log_q[base].data[191:128], 64'hA000_0001_A000_0000);
            check("t1_keep", log_q[base].keep, 16'h003F);
            check("t1_user", log_q[base].user[31:0], 32'h5410_0F0F);
        end

        // 3-DW MRd, len 0 => 1024 DW
        base = log_q.size();
        mk(32'h0000_0000, 32'h0100_02FF, 32'h8000_0100, 32'h0, 3, 0, 32'h0);
        send_tlp(1'b0, 99);
        drain();
        check("t2_beats", 32'(log_q.size() - base), 32'd1);
        if (log_q.size() > base) begin
            check("t2_desc", log_q[base].data[127:0], 128'h0100_0002_0100_0400_0000_0000_8000_0100);
            check("t2_keep", log_q[base].keep, 16'h000F);
            check("t2_last", log_q[base].last, 1'b1);
        end

        // 3-DW MWr, len 29: second beat full, so a trailing flush beat follows
        base = log_q.size();
        mk(32'h4000_001D, 32'h0100_03FF, 32'h0000_2000, 32'h0, 3, 29, 32'hB000_0000);
        send_tlp(1'b0, 99);
        check("t3_flush_tready_a", bus.s_axis_rq_tready_a, 1'b0);
        check("t3_flush_tvalid", bus.s_axis_rq_tvalid, 1'b1);
        check("t3_flush_keep", bus.s_axis_rq_tkeep, 16'h0001);
        drain();
        check("t3_beats", 32'(log_q.size() - base), 32'd3);
        if (log_q.size() > base + 2) begin
            check("t3_first_payload", log_q[base].data[159:128], 32'hB000_0000);
            check("t3_mid_dw0", log_q[base+1].data[31:0], 32'hB000_000C);
            check("t3_flush_dw0", log_q[base+2].data[31:0], 32'hB000_001C);
        end

        // 64-DW 3-DW MWr under random backpressure
        base = log_q.size();
        bp_en = 1'b1;
        mk(32'h4000_0040, 32'h0100_07FF, 32'h0000_3000, 32'h0, 3, 64, 32'hD000_0000);
        send_tlp(1'b0, 99);
        drain();
        bp_en = 1'b0;
        repeat (2) @(posedge user_clk);
        #1;
        check("t4_beats", 32'(log_q.size() - base), 32'd5);
        if (log_q.size() > base + 4) check("t4_last_keep", log_q[base+4].keep, 16'h000F);

        // Cfg read and a 2-beat message are dropped; the MRd that follows is intact
        base = log_q.size();
        mk(32'h0400_0001, 32'h0100_04FF, 32'h0000_0010, 32'h0, 3, 0, 32'h0);
        send_tlp(1'b0, 99);
        mk(32'h7000_0010, 32'h0100_08FF, 32'h0, 32'h0, 4, 16, 32'hE000_0000);
        send_tlp(1'b0, 99);
        mk(32'h2000_0004, 32'h0100_05FF, 32'h0000_0002, 32'h0000_4000, 4, 0, 32'h0);
        send_tlp(1'b0, 99);
        drain();
        check("t5_beats", 32'(log_q.size() - base), 32'd1);
        if (log_q.size() > base)
            check("t5_desc", log_q[base].data[127:0], 128'h0100_0005_0100_0004_0000_0002_0000_4000);

        // IOWr with discontinue
        base = log_q.size();
        mk(32'h4200_0001, 32'h0100_060F, 32'h0000_0080, 32'h0, 3, 1, 32'hC0DE_0001);
        send_tlp(1'b1, 99);
        drain();
        check("t6_beats", 32'(log_q.size() - base), 32'd1);
        if (log_q.size() > base) begin
            check("t6_desc_dw2", log_q[base].data[95:64], 32'h0100_1801);
            check("t6_disc", log_q[base].user[36], 1'b1);
            check("t6_keep", log_q[base].keep, 16'h001F);
        end

        // Reset while a 3-DW TLP is mid-flight
        mk(32'h4000_001D, 32'h0100_0AFF, 32'h0000_6000, 32'h0, 3, 29, 32'h9000_0000);
        send_tlp(1'b0, 1);
        user_reset = 1'b1;
        @(negedge user_clk);
        check("t7_reset_tvalid", bus.s_axis_rq_tvalid, 1'b0);
        check("t7_reset_tready_a", bus.s_axis_rq_tready_a, 1'b0);
        exp_q.delete();
        @(posedge user_clk);
        #1;
        user_reset = 1'b0;
        @(posedge user_clk);
        #1;
        base = log_q.size();
        mk(32'h4000_000D, 32'h0100_09FF, 32'h0000_5000, 32'h0, 3, 13, 32'hF000_0000);
        send_tlp(1'b0, 99);
        drain();
        check("t7_beats", 32'(log_q.size() - base), 32'd2);
        if (log_q.size() > base + 1) begin
            check("t7_sop", log_q[base].user[20], 1'b1);
            check("t7_flush_dw0", log_q[base+1].data[31:0], 32'hF000_000C);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/s_axis_rq_adapt_x16.md
# s_axis_rq_adapt_x16

Converts outbound requester TLPs on the 512-bit user stream from legacy PCIe TLP header format into the UltraScale+ x16 Requester Request (RQ) descriptor format. It is the transmit-side counterpart of the RC completion adapter and sits between the LitePCIe TLP packetizer and the hard block's `s_axis_rq` port. The block rewrites the header into a 4-DW descriptor and realigns the payload of 3-DW-header requests by one DW. It can emit an extra trailing beat when that realignment overflows, and it drops request types the RQ port cannot carry.

## Interface
- DATA_WIDTH, 512, stream data width in bits; only 512 is supported.
- KEEP_WIDTH, DATA_WIDTH/32, output DW-enable width.

- user_clk  in  1  clock.
- user_reset  in  1  synchronous, active-high reset.
- s_axis_rq_tdata_a  in  512  legacy TLP; DW0 in [31:0], native PCIe field positions.
- s_axis_rq_tkeep_a  in  64  byte enables (contiguous from byte 0).
- s_axis_rq_tlast_a  in  1  last beat of TLP.
- s_axis_rq_tuser_a  in  1  discontinue request.
- s_axis_rq_tvalid_a  in  1  input valid.
- s_axis_rq_tready_a  out  1  input ready.
- s_axis_rq_tdata  out  512  RQ descriptor + payload.
- s_axis_rq_tkeep  out  16  DW enables.
- s_axis_rq_tlast  out  1  last beat.
- s_axis_rq_tuser  out  137  RQ sideband; the fields used are listed under Operation, all other bits are 0.
- s_axis_rq_tvalid  out  1  output valid.
- s_axis_rq_tready  in  4  core ready; only bit 0 is used.

## Operation
- Header decode happens on the SOP beat, which is the first beat after reset or after a beat with tlast.
  - fmt = DW0[31:29], type = DW0[28:24], tc = DW0[22:20], ep = DW0[14], attr = DW0[13:12], len = DW0[9:0].
  - reqid = DW1[31:16], tag = DW1[15:8], lastBE = DW1[7:4], firstBE = DW1[3:0].
  - 4-DW header when fmt[0]=1.
- Request type mapping:
  - MRd (type 00000) maps to 0000.
  - MWr (type 00000, fmt[1]=1) maps to 0001.
  - IORd (type 00010) maps to 0010.
  - IOWr maps to 0011.
  - Any other type is unsupported.
- Descriptor, 128 bits, placed in output DW0-3:
  - [1:0] = 00.
  - [63:2] = address: 4-DW header gives {DW2, DW3[31:2]}; 3-DW header gives {32'h0, DW2[31:2]}.
  - [74:64] = dword count {len==0, len}, so len 0 encodes 1024.
  - [78:75] = request type.
  - [79] = ep.
  - [95:80] = reqid.
  - [103:96] = tag.
  - [119:104] = 0.
  - [120] = 1.
  - [123:121] = tc.
  - [126:124] = {1'b0, attr}.
  - [127] = 0.
- Output tuser fields:
  - [3:0] = firstBE and [11:8] = lastBE, valid on the SOP beat only.
  - [20] = is_sop.
  - [26] = is_eop.
  - [31:28] = eop0_ptr, the index of the last valid DW on the tlast beat.
  - [36] = discontinue; s_axis_rq_tuser_a is forwarded, and on a FLUSH beat the value latched from the last input beat is used.
- State machine: SOP, PASS4, SHIFT3, FLUSH, DROP.
  - SOP with a 4-DW header: output DW4-15 are input DW4-15 and tkeep = input DW enables. Go to PASS4 if not tlast.
  - SOP with a 3-DW header: output DW4-15 are input DW3-14, and input DW15 is saved in the carry register. Go to SHIFT3 if not tlast. If tlast and input DW15 is valid, go to FLUSH.
  - PASS4: data passes through unmodified.
  - SHIFT3: output = {input DW0-14, carry}; carry is reloaded with input DW15. On tlast, go to FLUSH if input DW15 is valid, otherwise go to SOP.
  - FLUSH: emit a single beat with DW0 = carry, tkeep = 16'h0001 and tlast = 1, with s_axis_rq_tready_a = 0. Go to SOP.
  - Unsupported type on the SOP beat: consume the input (tready_a = 1) with no output (tvalid = 0). Stay in DROP until a tlast beat is consumed, then go to SOP.
- Reset: state returns to SOP, carry is cleared, and all outputs are 0 (tvalid = 0, tready_a = 0) while user_reset is high. A TLP in flight at reset is abandoned and is not completed afterwards.

## Timing
- Base build: the output is combinational from the input plus state, so latency is 0 cycles.
  - s_axis_rq_tvalid = s_axis_rq_tvalid_a in the SOP (supported type), PASS4 and SHIFT3 states; = 1 in FLUSH.
  - s_axis_rq_tready_a = s_axis_rq_tready[0] outside FLUSH and DROP.
- Registered state: state and carry advance only on an input handshake. In FLUSH they advance on s_axis_rq_tvalid && s_axis_rq_tready[0].
- Throughput is one beat per cycle. The only bubble is the FLUSH beat.
- Output is held stable while tvalid && !tready[0].

## Configuration
- S_AXIS_RQ_ADAPT_X16_OUTREG_EN defined: all outputs come from a 2-entry skid register stage.
  - Latency is 1 cycle and full throughput is kept.
  - s_axis_rq_tready_a no longer depends combinationally on s_axis_rq_tready.
  - The skid stage is cleared to empty on reset.
- Macro undefined: combinational output as described under Timing.

## Test plan
- 4-DW MWr, len=2, addr 0x1_2345_6780, tag 0x15, BE F/F, one beat → one output beat:
  - descriptor [63:0] = 0x0000_0001_2345_6780, [74:64] = 2, [78:75] = 0001, [103:96] = 0x15.
  - tkeep = 0x003F, eop0_ptr = 5.
- 3-DW MRd, len=0, addr 0x8000_0100 → single beat:
  - dword count = 1024, type 0000, tkeep = 0x000F, tlast = 1.
- 3-DW MWr, len=29, two input beats (second beat keeps DW0-15):
  - three output beats, the last being a FLUSH beat with tkeep = 0x0001.
  - tready_a = 0 during FLUSH.
  - payload DW order matches the input exactly.
- Random tready[0] backpressure on a 64-DW 3-DW MWr → no data loss or duplication, and output is held stable while stalled.
- Cfg read (type 00100) followed by a 4-DW MRd → the Cfg TLP is consumed with no output; the MRd is emitted intact.
- user_reset asserted mid-SHIFT3 → the next cycle shows tvalid = 0; the following TLP is decoded as SOP with the carry cleared.
